sar_adc_out_if: RTL and testbench



---
 rtl/sar_adc_out_if.sv | 163 ++++++++++++++++
 tb/tb_sar_adc_out_if.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_adc_out_if.sv
// SAR ADC core-to-pad output interface: READY synchroniser, optional 1/2/4/8-sample
// averaging, registered parallel result bus and MSB-first serial stream with overrun flag.
module sar_adc_out_if #(
  parameter int NBITS        = 11,
  parameter int MODE_W       = 3,
  parameter int MAX_AVG_LOG2 = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NBITS-1:0]  CORE_B,
  input  logic              CORE_READY,
  input  logic [MODE_W-1:0] CORE_C,
  output logic [NBITS-1:0]  PAD_B_OUT,
  output logic              PAD_READY_OUT,
  output logic              SER_DO,
  output logic              SER_FRAME,
  output logic              OVR
);

  localparam int ACC_W = NBITS + MAX_AVG_LOG2;
  localparam int CNT_W = (MAX_AVG_LOG2 > 0) ? MAX_AVG_LOG2 : 1;
  localparam int BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  // Averaging exponent requested by the mode pins, limited to what the accumulator holds.
  function automatic logic [1:0] clamp_sel(input logic [1:0] c);
    if (int'(c) > MAX_AVG_LOG2) return 2'(MAX_AVG_LOG2);
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] last_cnt(input logic [1:0] sel);
    return CNT_W'((32'd1 << sel) - 32'd1);
  endfunction

  // Divide by 2^sel with plain truncation toward zero.
  function automatic logic [NBITS-1:0] avg_trunc(input logic [ACC_W-1:0] sum,
                                                 input logic [1:0]       sel);
    logic [ACC_W-1:0] q;
    q = sum >> sel;
    return q[NBITS-1:0];
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rdy_prev_q;
  logic                   vld_p0;

  logic [ACC_W-1:0]       acc_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [1:0]             sel_q;
  logic                   ser_q;

  ser_state_t             state_q;
  logic [NBITS-1:0]       sh_q;
  logic [BIT_W-1:0]       bit_cnt_q;

  logic                   cnt_zero;
  logic [1:0]             sel_eff;
  logic                   ser_eff;
  logic [ACC_W-1:0]       sum;
  logic                   avg_last;
  logic                   upd;
  logic [NBITS-1:0]       res;
  logic                   ser_load;
  logic                   ser_ovr;

  // Stage p0: READY synchroniser and registered rising-edge strobe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q     <= '0;
      rdy_prev_q <= 1'b0;
      vld_p0     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], CORE_READY};
      rdy_prev_q <= sync_q[SYNC_STAGES-1];
      vld_p0     <= sync_q[SYNC_STAGES-1] & ~rdy_prev_q;
    end
  end

  // Mode is taken from the pins only at the first sample of an average.
  always_comb begin
    cnt_zero = (cnt_q == '0);
    sel_eff  = cnt_zero ? clamp_sel(CORE_C[1:0]) : sel_q;
    ser_eff  = cnt_zero ? CORE_C[2] : ser_q;
    sum      = acc_q + ACC_W'(CORE_B);
    avg_last = (cnt_q == last_cnt(sel_eff));
    upd      = vld_p0 & avg_last;
    res      = avg_trunc(sum, sel_eff);
    ser_load = upd & ser_eff & ((state_q == IDLE) || (bit_cnt_q == '0));
    ser_ovr  = upd & ser_eff & (state_q == SHIFT) & (bit_cnt_q != '0);
  end

  // Stage p1: accumulate on every strobe, publish on the last sample of the average.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q         <= '0;
      cnt_q         <= '0;
      sel_q         <= '0;
      ser_q         <= 1'b0;
      PAD_B_OUT     <= '0;
      PAD_READY_OUT <= 1'b0;
    end else begin
      PAD_READY_OUT <= upd;
      if (vld_p0) begin
        if (cnt_zero) begin
          sel_q <= sel_eff;
          ser_q <= ser_eff;
        end
        if (avg_last) begin
          acc_q     <= '0;
          cnt_q     <= '0;
          PAD_B_OUT <= res;
        end else begin
          acc_q <= sum;
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Serial FSM: bit_cnt_q counts the bits still to follow the one on SER_DO, so a
  // new word may reload on the last bit without a gap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      SER_DO    <= 1'b0;
      SER_FRAME <= 1'b0;
      OVR       <= 1'b0;
    end else begin
      if (ser_ovr) OVR <= 1'b1;
      if (ser_load) begin
        state_q   <= SHIFT;
        sh_q      <= res << 1;
        bit_cnt_q <= BIT_W'(NBITS - 1);
        SER_DO    <= res[NBITS-1];
        SER_FRAME <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            SER_DO    <= 1'b0;
            SER_FRAME <= 1'b0;
          end
          SHIFT: begin
            if (bit_cnt_q != '0) begin
              SER_DO    <= sh_q[NBITS-1];
              sh_q      <= sh_q << 1;
              bit_cnt_q <= bit_cnt_q - BIT_W'(1);
            end else begin
              state_q   <= IDLE;
              SER_DO    <= 1'b0;
              SER_FRAME <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sar_adc_out_if.sv
// Bench for sar_adc_out_if: directed scenarios plus random READY pulses, checked every
// cycle against a sample-level model that schedules expected outputs by cycle number.
module tb_sar_adc_out_if;

  localparam int NBITS = 11;
  localparam int NCYC  = 8192;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NBITS-1:0] core_b = '0;
  logic             core_ready = 1'b0;
  logic [2:0]       core_c = '0;
  logic [NBITS-1:0] pad_b;
  logic             pad_rdy;
  logic             ser_do;
  logic             ser_frame;
  logic             ovr;

  sar_adc_out_if #(
    .NBITS(NBITS), .MODE_W(3), .MAX_AVG_LOG2(3), .SYNC_STAGES(2)
  ) dut (
    .CLK(clk), .RST(rst), .CORE_B(core_b), .CORE_READY(core_ready), .CORE_C(core_c),
    .PAD_B_OUT(pad_b), .PAD_READY_OUT(pad_rdy), .SER_DO(ser_do), .SER_FRAME(ser_frame),
    .OVR(ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected events per cycle, filled in when a READY pulse is issued.
  bit               m_upd [NCYC];
  logic [NBITS-1:0] m_val [NCYC];
  bit               m_frm [NCYC];
  bit               m_do  [NCYC];
  bit               m_ovr [NCYC];
  int               m_sum = 0;
  int               m_cnt = 0;
  int               m_sel = 0;
  bit               m_ser = 0;
  int               m_busy_end = 0;

  task automatic model_sample(input int t, input logic [NBITS-1:0] b, input logic [2:0] c);
    int u;
    logic [NBITS-1:0] v;
    if (m_cnt == 0) begin
      m_sel = int'(c[1:0]);
      m_ser = c[2];
    end
    m_sum += int'(b);
    m_cnt++;
    if (m_cnt == (1 << m_sel)) begin
      v = NBITS'(m_sum / (1 << m_sel));
      u = t + 4;
      if (u + NBITS >= NCYC) begin
        $display("FAIL model_range: cycle %0d beyond table %0d", u, NCYC);
        $fatal(1);
      end
      m_upd[u] = 1'b1;
      m_val[u] = v;
      if (m_ser) begin
        if (u < m_busy_end) m_ovr[u] = 1'b1;
        else begin
          for (int k = 0; k < NBITS; k++) begin
            m_frm[u+k] = 1'b1;
            m_do[u+k]  = v[NBITS-1-k];
          end
          m_busy_end = u + NBITS;
        end
      end
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  task automatic model_reset(input int r);
    for (int i = r; i < NCYC; i++) begin
      m_upd[i] = 1'b0; m_val[i] = '0; m_frm[i] = 1'b0; m_do[i] = 1'b0; m_ovr[i] = 1'b0;
    end
    m_sum = 0; m_cnt = 0; m_busy_end = 0;
  endtask

  // Per-cycle comparison against the model, plus event monitors for directed checks.
  logic [NBITS-1:0] e_b = '0;
  bit               e_ovr = 1'b0;
  int rdy_cnt = 0, rdy_last = -1, run = 0, run_last = 0, frm_cyc = 0;

  always @(negedge clk) begin
    if (cyc < NCYC) begin
      if (rst) begin
        e_b   = '0;
        e_ovr = 1'b0;
      end else begin
        if (m_upd[cyc]) e_b = m_val[cyc];
        if (m_ovr[cyc]) e_ovr = 1'b1;
      end
      chk("pad_b", 32'(pad_b), 32'(e_b));
      chk("pad_rdy", 32'(pad_rdy), rst ? 32'd0 : 32'(m_upd[cyc]));
      chk("ser_frame", 32'(ser_frame), rst ? 32'd0 : 32'(m_frm[cyc]));
      chk("ser_do", 32'(ser_do), rst ? 32'd0 : 32'(m_do[cyc]));
      chk("ovr", 32'(ovr), 32'(e_ovr));
    end
    if (pad_rdy) begin
      rdy_cnt++;
      rdy_last = cyc;
    end
    if (ser_frame) begin
      run++;
      frm_cyc++;
    end else if (run != 0) begin
      run_last = run;
      run = 0;
    end
  end

  // Called just after a rising edge; returns hi+gap cycles later, just after an edge.
  task automatic pulse(input logic [NBITS-1:0] b, input logic [2:0] c,
                       input int hi, input int gap, output int t);
    core_b     = b;
    core_c     = c;
    core_ready = 1'b1;
    t = cyc;
    model_sample(t, b, c);
    repeat (hi) @(posedge clk);
    #1;
    core_ready = 1'b0;
    core_b     = NBITS'($urandom);
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int hold);
    #1;
    rst = 1'b1;
    model_reset(cyc);
    #1;
    chk("async_rst_pad_b", 32'(pad_b), 32'd0);
    chk("async_rst_pad_rdy", 32'(pad_rdy), 32'd0);
    chk("async_rst_ser_do", 32'(ser_do), 32'd0);
    chk("async_rst_ser_frame", 32'(ser_frame), 32'd0);
    chk("async_rst_ovr", 32'(ovr), 32'd0);
    repeat (hold) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t, t2, r0, f0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Pass-through latency and value
    f0 = frm_cyc;
    pulse(11'h2A7, 3'b000, 5, 10, t);
    chk("pt_latency", 32'(rdy_last - t), 32'd4);
    chk("pt_value", 32'(pad_b), 32'h2A7);
    chk("pt_no_frame", 32'(frm_cyc - f0), 32'd0);

    // Average of four, single update after the fourth sample
    r0 = rdy_cnt;
    pulse(11'd100, 3'b010, 5, 5, t);
    pulse(11'd101, 3'b010, 5, 5, t);
    pulse(11'd102, 3'b010, 5, 5, t);
    chk("avg4_no_early_rdy", 32'(rdy_cnt - r0), 32'd0);
    pulse(11'd104, 3'b010, 5, 5, t);
    chk("avg4_one_rdy", 32'(rdy_cnt - r0), 32'd1);
    chk("avg4_value", 32'(pad_b), 32'd101);

    // Mode change mid-average waits for the boundary
    r0 = rdy_cnt;
    pulse(11'd200, 3'b010, 5, 5, t);
    pulse(11'd300, 3'b010, 5, 5, t);
    pulse(11'd400, 3'b000, 5, 5, t);
    pulse(11'd501, 3'b000, 5, 5, t);
    chk("modechg_rdy", 32'(rdy_cnt - r0), 32'd1);
    chk("modechg_value", 32'(pad_b), 32'd350);
    pulse(11'd77, 3'b000, 5, 5, t);
    chk("modechg_next_rdy", 32'(rdy_cnt - r0), 32'd2);
    chk("modechg_next_value", 32'(pad_b), 32'd77);

    // Serial word, READY spaced 20 cycles
    f0 = frm_cyc;
    pulse(11'h400, 3'b100, 5, 15, t);
    pulse(11'h3FF, 3'b100, 5, 20, t);
    chk("ser_frame_len", 32'(run_last), 32'd11);
    chk("ser_frame_total", 32'(frm_cyc - f0), 32'd22);
    chk("ser_no_ovr", 32'(ovr), 32'd0);

    // Overrun: second update lands mid-word
    pulse(11'h5A5, 3'b100, 4, 1, t);
    pulse(11'h0F0, 3'b100, 5, 25, t2);
    chk("ovr_set", 32'(ovr), 32'd1);
    chk("ovr_pad_b", 32'(pad_b), 32'h0F0);
    chk("ovr_frame_len", 32'(run_last), 32'd11);

    // Back-to-back: update on the last bit gives a seamless double frame
    pulse(11'h123, 3'b100, 5, 6, t);
    pulse(11'h456, 3'b100, 5, 30, t);
    chk("b2b_frame_len", 32'(run_last), 32'd22);
    chk("b2b_ovr_kept", 32'(ovr), 32'd1);

    // Reset mid-SHIFT
    pulse(11'h7FF, 3'b100, 5, 0, t);
    do_reset(2);
    idle(3);

    // Reset mid-average, then a fresh pass-through sample
    pulse(11'd10, 3'b010, 5, 3, t);
    pulse(11'd20, 3'b010, 5, 3, t);
    do_reset(2);
    idle(2);
    pulse(11'h155, 3'b000, 5, 8, t);
    chk("post_rst_value", 32'(pad_b), 32'h155);
    chk("post_rst_latency", 32'(rdy_last - t), 32'd4);

    // Random pulses, modes, spacing and occasional resets
    for (int i = 0; i < 60; i++) begin
      pulse(NBITS'($urandom), 3'($urandom_range(0, 7)), $urandom_range(4, 6),
            $urandom_range(1, 14), t);
      if ($urandom_range(0, 19) == 0) begin
        do_reset(2);
        idle(2);
      end
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
